// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution datapath (controller, MAC array, bench).
package conv_pkg;

  // MAC array control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mac_state_t;

  // Number of operand lanes for a KxK kernel.
  function automatic int unsigned N_LANES(input int unsigned k);
    return k * k;
  endfunction

  // Edges from the sampling edge (counted as the first) to cready: products, tree levels, output.
  function automatic int unsigned mac_latency(input int unsigned k);
    return $clog2(k * k) + 2;
  endfunction

endpackage

// File: rtl/conv_mac_array_if.sv
// Operand/result bundle between the convolution controller (master) and the MAC array (slave).
// sat_flag exists only when CONV_MAC_SATURATE_EN is defined.
interface conv_mac_array_if
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KERNEL_SIZE = 3
) ();

  localparam int unsigned N = N_LANES(KERNEL_SIZE);

  logic [N*DATA_WIDTH-1:0] multiplier_in;
  logic [N*DATA_WIDTH-1:0] multiplicand_in;
  logic [N-1:0]            multiply_start;
  logic [DATA_WIDTH-1:0]   csum;
  logic                    cready;

`ifdef CONV_MAC_SATURATE_EN
  logic sat_flag;

  modport master (
    output multiplier_in, multiplicand_in, multiply_start,
    input  csum, cready, sat_flag
  );

  modport slave (
    input  multiplier_in, multiplicand_in, multiply_start,
    output csum, cready, sat_flag
  );
`else
  modport master (
    output multiplier_in, multiplicand_in, multiply_start,
    input  csum, cready
  );

  modport slave (
    input  multiplier_in, multiplicand_in, multiply_start,
    output csum, cready
  );
`endif

endinterface

// File: rtl/conv_adder_tree.sv
// Registered pairwise adder tree: one register level per halving, a valid bit per level and a
// synchronous flush that drops every in-flight valid bit. Requires LANES >= 2.
module conv_adder_tree #(
  parameter int unsigned LANES     = 9,
  parameter int unsigned ACC_WIDTH = 68
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic signed [ACC_WIDTH-1:0] in_data [LANES],
  output logic                        out_valid,
  output logic signed [ACC_WIDTH-1:0] out_sum
);

  localparam int unsigned LEVELS = $clog2(LANES);
  localparam int unsigned SRC_W  = 2 * LANES;

  // Live operand count entering level lvl; an odd leftover is passed through registered.
  function automatic int level_count(input int lvl);
    int c = int'(LANES);
    for (int j = 0; j < lvl; j++) c = (c + 1) / 2;
    return c;
  endfunction

  logic signed [ACC_WIDTH-1:0] src    [LEVELS][SRC_W];
  logic signed [ACC_WIDTH-1:0] node_q [LEVELS][LANES];
  logic [LEVELS-1:0]           valid_q;

  // Operands feeding each level: the inputs for the first, the previous level otherwise.
  always_comb begin
    for (int l = 0; l < int'(LEVELS); l++) begin
      for (int i = 0; i < int'(SRC_W); i++) src[l][i] = '0;
    end
    for (int i = 0; i < int'(LANES); i++) src[0][i] = in_data[i];
    for (int l = 1; l < int'(LEVELS); l++) begin
      for (int i = 0; i < int'(LANES); i++) src[l][i] = node_q[l-1][i];
    end
  end

  // Level registers and their valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int l = 0; l < int'(LEVELS); l++) begin
        for (int i = 0; i < int'(LANES); i++) node_q[l][i] <= '0;
      end
    end else begin
      if (flush) begin
        valid_q <= '0;
      end else begin
        for (int l = int'(LEVELS) - 1; l > 0; l--) valid_q[l] <= valid_q[l-1];
        valid_q[0] <= in_valid;
      end
      for (int l = 0; l < int'(LEVELS); l++) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (2 * i + 1 < level_count(l)) begin
            node_q[l][i] <= src[l][2*i] + src[l][2*i+1];
          end else if (2 * i < level_count(l)) begin
            node_q[l][i] <= src[l][2*i];
          end else begin
            node_q[l][i] <= '0;
          end
        end
      end
    end
  end

  assign out_valid = valid_q[LEVELS-1];
  assign out_sum   = node_q[LEVELS-1][0];

endmodule

// File: rtl/conv_mac_array.sv
// KxK signed multiply-accumulate engine: captures one window, reduces it through a registered
// adder tree and presents one result per window on csum/cready.
// Optional feature macro: CONV_MAC_SATURATE_EN (saturating reduction plus sticky sat_flag).
module conv_mac_array
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned FRAC_BITS   = 0
) (
  input logic             axi_clk,
  input logic             axi_reset_n,
  conv_mac_array_if.slave bus
);

  localparam int unsigned N  = N_LANES(KERNEL_SIZE);
  localparam int unsigned L  = $clog2(N);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = 2 * DW + L;

  // Full-precision lane product, sign-extended to accumulator width.
  function automatic logic signed [AW-1:0] lane_product(input logic signed [DW-1:0] a,
                                                        input logic signed [DW-1:0] b);
    logic signed [2*DW-1:0] p;
    p = a * b;
    return {{L{p[2*DW-1]}}, p};
  endfunction

  mac_state_t state_q, state_d;
  logic       any_start;
  logic       capture;
  logic       abort;
  logic       load_out;

  logic signed [AW-1:0] prod_q [N];
  logic                 prod_valid_q;
  logic                 tree_valid;
  logic signed [AW-1:0] tree_sum;

  logic [DW-1:0] reduced;
  logic [DW-1:0] csum_q;
  logic          cready_q;

  assign any_start = |bus.multiply_start;

  // Window control: capture in IDLE, abort on a start drop in RUN, hold result in DONE.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    abort    = 1'b0;
    load_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_start) begin
          capture = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // A drop on the edge the tree finishes still aborts.
        if (!any_start) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (tree_valid) begin
          load_out = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!any_start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Product stage: operands are sampled only on the capture edge; masked lanes contribute 0.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      prod_valid_q <= 1'b0;
      for (int i = 0; i < int'(N); i++) prod_q[i] <= '0;
    end else begin
      prod_valid_q <= capture;
      if (capture) begin
        for (int i = 0; i < int'(N); i++) begin
          prod_q[i] <= bus.multiply_start[i]
                       ? lane_product(bus.multiplier_in[i*DW +: DW],
                                      bus.multiplicand_in[i*DW +: DW])
                       : '0;
        end
      end
    end
  end

  conv_adder_tree #(
    .LANES    (N),
    .ACC_WIDTH(AW)
  ) u_tree (
    .clk      (axi_clk),
    .rst_n    (axi_reset_n),
    .flush    (abort),
    .in_valid (prod_valid_q),
    .in_data  (prod_q),
    .out_valid(tree_valid),
    .out_sum  (tree_sum)
  );

`ifdef CONV_MAC_SATURATE_EN
  logic signed [AW-1:0] shifted;
  logic                 overflow;
  logic                 sat_q;

  assign shifted = tree_sum >>> FRAC_BITS;

  // Clamp to the signed DW range when the scaled sum does not fit.
  always_comb begin
    overflow = (shifted[AW-1:DW-1] != {(AW - DW + 1){shifted[AW-1]}});
    if (!overflow) begin
      reduced = shifted[DW-1:0];
    end else if (shifted[AW-1]) begin
      reduced = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      reduced = {1'b0, {(DW - 1){1'b1}}};
    end
  end

  // Sticky clamp indicator, cleared when the next window is captured.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      sat_q <= 1'b0;
    end else if (capture) begin
      sat_q <= 1'b0;
    end else if (load_out && overflow) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.sat_flag = sat_q;
`else
  // Two's-complement wrap of the scaled sum.
  assign reduced = DW'(tree_sum >>> FRAC_BITS);
`endif

  // State and output register; csum keeps its value after the window closes.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q  <= IDLE;
      csum_q   <= '0;
      cready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cready_q <= (state_d == DONE);
      if (load_out) csum_q <= reduced;
    end
  end

  assign bus.csum   = csum_q;
  assign bus.cready = cready_q;

endmodule
